// File: rtl/bcd_display_scanner_pkg.sv
// Shared BCD definitions for the display path: digit type, largest legal
// code and a validity check. The 7-seg decoder and the ADC result counter
// import this same package so all three agree on what a digit is.
package display_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // True when the nibble is a decimal digit (0..9).
  function automatic logic is_bcd(bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Bundle between the ADC result latch / display consumer and the digit
// scanner. The master side loads new results and observes the scan outputs;
// the slave side is the scanner itself.
interface bcd_display_scanner_if #(
  parameter int N_DIGITS = 4
);

  logic                    load;
  logic [4*N_DIGITS-1:0]   digits_in;
  logic [3:0]              bcd_out;
  logic [N_DIGITS-1:0]     digit_en;
  logic                    frame_done;
  logic                    pending;

  modport master (
    output load, digits_in,
    input  bcd_out, digit_en, frame_done, pending
  );

  modport slave (
    input  load, digits_in,
    output bcd_out, digit_en, frame_done, pending
  );

endinterface

// File: rtl/bcd_display_scanner_tick.sv
// Slot prescaler for the digit scanner: counts 0..DIV-1 and flags the last
// count of each slot so the scanner can advance to the next digit.
module scan_tick_gen #(
  parameter int DIV = 1000,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] count,
  output logic          tick
);

  // Last cycle of the slot; the counter wraps on the following edge.
  assign tick = (count == CW'(DIV - 1));

  // Free-running slot counter that restarts at zero after each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed BCD display scanner. One digit slot at a time is presented on
// bcd_out with its common-electrode enable, after a short all-off blanking
// window at the start of each slot to avoid ghosting. New results land in a
// shadow register and are copied to the display register only when a frame
// wraps, so a frame never mixes old and new digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zeros on
// digits above digit 0, evaluated on the displayed value).
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int SCAN_DIV      = 1000,
  parameter int BLANK_CYCLES  = 2,
  parameter int EN_ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  bcd_display_scanner_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] EN_OFF =
    (EN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_next;
  logic                    tick;
  logic                    wrap;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_next;
  logic [4*N_DIGITS-1:0]   shadow;
  logic [4*N_DIGITS-1:0]   display;
  logic [4*N_DIGITS-1:0]   display_next;
  logic                    pending_r;
  logic [N_DIGITS-1:0]     lit_mask;
  bcd_digit_t              cur_digit;
  logic                    slot_on;
  logic [3:0]              bcd_next;
  logic [N_DIGITS-1:0]     en_next;
  logic [3:0]              bcd_r;
  logic [N_DIGITS-1:0]     en_r;
  logic                    frame_r;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .count (cnt),
    .tick  (tick)
  );

  assign wrap = tick && (idx == IW'(N_DIGITS - 1));

  // Next prescaler/slot/display values, so the registered outputs line up
  // with the state they describe instead of lagging it by a cycle.
  always_comb begin
    cnt_next     = tick ? '0 : cnt + CW'(1);
    idx_next     = idx;
    display_next = display;
    if (tick) begin
      idx_next = wrap ? '0 : idx + IW'(1);
    end
    if (wrap && pending_r) begin
      display_next = shadow;
    end
  end

  // Which digits may light at all; with leading-zero blanking a zero digit
  // is dark when every digit above it is also zero. Digit 0 always lights.
  always_comb begin
    lit_mask = '1;
`ifdef LEADING_ZERO_BLANK_EN
    begin : lzb
      logic higher_zero;
      higher_zero = 1'b1;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
        higher_zero = higher_zero && (display_next[4*k +: 4] == 4'd0);
        lit_mask[k] = !higher_zero;
      end
    end
`endif
  end

  // Select the slot's digit, squash non-BCD codes to 0 and build the
  // one-hot enable, held off during the blanking window and for bad digits.
  always_comb begin
    cur_digit = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_next == IW'(k)) begin
        cur_digit = display_next[4*k +: 4];
      end
    end
    slot_on  = (cnt_next >= CW'(BLANK_CYCLES)) && is_bcd(cur_digit);
    bcd_next = is_bcd(cur_digit) ? cur_digit : 4'd0;
    en_next  = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      en_next[k] = slot_on && (idx_next == IW'(k)) && lit_mask[k];
    end
  end

  // Scan position, double-buffered digit registers and the pending flag;
  // a load coinciding with a frame wrap keeps pending set for the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      shadow    <= '0;
      display   <= '0;
      pending_r <= 1'b0;
    end else begin
      idx     <= idx_next;
      display <= display_next;
      if (bus.load) begin
        shadow <= bus.digits_in;
      end
      pending_r <= bus.load ? 1'b1 : (wrap ? 1'b0 : pending_r);
    end
  end

  // Registered display outputs with driver polarity applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_r   <= '0;
      en_r    <= EN_OFF;
      frame_r <= 1'b0;
    end else begin
      bcd_r   <= bcd_next;
      en_r    <= en_next ^ EN_OFF;
      frame_r <= wrap;
    end
  end

  assign bus.bcd_out    = bcd_r;
  assign bus.digit_en   = en_r;
  assign bus.frame_done = frame_r;
  assign bus.pending    = pending_r;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (4 digits, 4 cycles per slot,
// 1 blanking cycle). A cycle-accurate reference of the scan position and the
// shadow/display buffers produces expected outputs into a scoreboard queue;
// table records additionally check whole frames against literal digits.
// Define LEADING_ZERO_BLANK_EN to run the active-low, zero-blanking variant.
`timescale 1ns/1ps
module tb_bcd_display_scanner;

  localparam int N_DIGITS     = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 1;
`ifdef LEADING_ZERO_BLANK_EN
  localparam int EN_ACTIVE_LOW = 1;
`else
  localparam int EN_ACTIVE_LOW = 0;
`endif
  localparam logic [3:0] EN_OFF = (EN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  typedef struct {
    logic [3:0] bcd;
    logic [3:0] en;
    logic       fd;
    logic       pend;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    int          offset;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_lit;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  bcd_display_scanner_if #(.N_DIGITS(N_DIGITS)) bus();

  bcd_display_scanner #(
    .N_DIGITS      (N_DIGITS),
    .SCAN_DIV      (SCAN_DIV),
    .BLANK_CYCLES  (BLANK_CYCLES),
    .EN_ACTIVE_LOW (EN_ACTIVE_LOW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          vectors    = 0;
  int          miscompares = 0;
  int          k;
  logic [15:0] mdisp;
  logic [15:0] mshadow;
  logic        mpend;
  exp_t        sb_q[$];
  vec_t        tbl[5];

  // Expected outputs for cycle kk since reset, given the displayed value.
  function automatic exp_t model_out(int kk, logic [15:0] disp, logic pend);
    exp_t       e;
    int         slot;
    int         ph;
    logic [3:0] d;
    logic       lit;
    slot = (kk / 4) % 4;
    ph   = kk % 4;
    d    = disp[slot*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    lit = (slot == 0) || ((disp >> (4 * slot)) != 16'h0000);
`else
    lit = 1'b1;
`endif
    e.bcd  = (d <= 4'd9) ? d : 4'd0;
    e.en   = ((ph >= 1) && (d <= 4'd9) && lit) ? (4'b0001 << slot) : 4'b0000;
    e.en   = e.en ^ EN_OFF;
    e.fd   = ((kk % 16) == 0) && (kk != 0);
    e.pend = pend;
    return e;
  endfunction

  task automatic checkOutput(input string tag);
    exp_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s k=%0d: scoreboard empty, nothing to compare", tag, k);
      return;
    end
    e = sb_q.pop_front();
    if (bus.bcd_out !== e.bcd || bus.digit_en !== e.en ||
        bus.frame_done !== e.fd || bus.pending !== e.pend) begin
      miscompares++;
      $display("[TB] FAIL %s k=%0d: got bcd=%h en=%b fd=%b pend=%b, expected bcd=%h en=%b fd=%b pend=%b",
               tag, k, bus.bcd_out, bus.digit_en, bus.frame_done, bus.pending,
               e.bcd, e.en, e.fd, e.pend);
    end
  endtask

  task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // One clock: drive inputs, advance the reference, queue its expectation,
  // then compare at the falling edge.
  task automatic applyStimulus(input logic ld, input logic [15:0] d, input string tag);
    bus.load      = ld;
    bus.digits_in = d;
    @(posedge clk);
    k++;
    if ((k % 16) == 0 && mpend) begin
      mdisp = mshadow;
      mpend = 1'b0;
    end
    if (ld) begin
      mshadow = d;
      mpend   = 1'b1;
    end
    sb_q.push_back(model_out(k, mdisp, mpend));
    @(negedge clk);
    bus.load = 1'b0;
    checkOutput(tag);
  endtask

  // Idle cycles with junk on digits_in, which must be ignored without load.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 16'($urandom), "scan");
    end
  endtask

  task automatic waitOffset(input int o);
    for (int i = 0; i < 32 && (k % 16) != o; i++) begin
      applyStimulus(1'b0, 16'($urandom), "scan");
    end
  endtask

  // Runs one frame from a wrap, recording mid-slot digit and own-enable state.
  task automatic captureFrame(output logic [15:0] fb, output logic [3:0] fl);
    int slot;
    fb = '0;
    fl = '0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 16'($urandom), "frame");
      if ((k % 4) == 2) begin
        slot = (k % 16) / 4;
        fb[slot*4 +: 4] = bus.bcd_out;
        fl[slot] = (EN_ACTIVE_LOW != 0) ? ~bus.digit_en[slot] : bus.digit_en[slot];
      end
    end
  endtask

  initial begin
    logic [15:0] fb;
    logic [3:0]  fl;

    tbl[0] = '{data: 16'h1234, offset: 3, exp_bcd: 16'h1234, exp_lit: 4'b1111};
    tbl[1] = '{data: 16'h5678, offset: 9, exp_bcd: 16'h5678, exp_lit: 4'b1111};
`ifdef LEADING_ZERO_BLANK_EN
    tbl[2] = '{data: 16'h00A3, offset: 0, exp_bcd: 16'h0003, exp_lit: 4'b0001};
    tbl[3] = '{data: 16'h0042, offset: 6, exp_bcd: 16'h0042, exp_lit: 4'b0011};
    tbl[4] = '{data: 16'h0000, offset: 13, exp_bcd: 16'h0000, exp_lit: 4'b0001};
`else
    tbl[2] = '{data: 16'h00A3, offset: 0, exp_bcd: 16'h0003, exp_lit: 4'b1101};
    tbl[3] = '{data: 16'h0042, offset: 6, exp_bcd: 16'h0042, exp_lit: 4'b1111};
    tbl[4] = '{data: 16'h0000, offset: 13, exp_bcd: 16'h0000, exp_lit: 4'b1111};
`endif

    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    k       = 0;
    mdisp   = '0;
    mshadow = '0;
    mpend   = 1'b0;
    sb_q.push_back(model_out(k, mdisp, mpend));
    checkOutput("reset");

    // Table: load at a given frame offset, then check the following frame.
    for (int i = 0; i < 5; i++) begin
      waitOffset(tbl[i].offset);
      applyStimulus(1'b1, tbl[i].data, "load");
      waitOffset(0);
      captureFrame(fb, fl);
      checkValue($sformatf("frame_bcd[%0d]", i), fb, tbl[i].exp_bcd);
      checkValue($sformatf("frame_lit[%0d]", i), {12'h000, fl}, {12'h000, tbl[i].exp_lit});
    end

    // Two loads in one frame: only the second reaches the display.
    waitOffset(2);
    applyStimulus(1'b1, 16'h1111, "dbl_load1");
    waitOffset(9);
    applyStimulus(1'b1, 16'h2222, "dbl_load2");
    waitOffset(0);
    captureFrame(fb, fl);
    checkValue("double_load_bcd", fb, 16'h2222);

    // Load on the wrap edge: old shadow shows now, new value one frame later.
    waitOffset(3);
    applyStimulus(1'b1, 16'h4444, "wrap_load1");
    waitOffset(15);
    applyStimulus(1'b1, 16'h7777, "wrap_load2");
    captureFrame(fb, fl);
    checkValue("wrap_load_first", fb, 16'h4444);
    captureFrame(fb, fl);
    checkValue("wrap_load_second", fb, 16'h7777);

    // Asynchronous reset mid-slot with a live digit and a pending load.
    waitOffset(1);
    applyStimulus(1'b1, 16'h9876, "pre_rst_load");
    waitOffset(0);
    waitOffset(5);
    applyStimulus(1'b1, 16'h3333, "pre_rst_pend");
    rst = 1'b1;
    #1;
    checkValue("rst_bcd", {12'h000, bus.bcd_out}, 16'h0000);
    checkValue("rst_en", {12'h000, bus.digit_en}, {12'h000, EN_OFF});
    checkValue("rst_frame_done", {15'h0000, bus.frame_done}, 16'h0000);
    checkValue("rst_pending", {15'h0000, bus.pending}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    k       = 0;
    mdisp   = '0;
    mshadow = '0;
    mpend   = 1'b0;
    sb_q.delete();
    sb_q.push_back(model_out(k, mdisp, mpend));
    checkOutput("post_reset");
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
